// File: rtl/sync_cell_bus.sv
// sync_cell_bus: per-bit multi-flop synchroniser with optional stability filter
// and registered rise/fall pulses for a bus of independent asynchronous levels.
module sync_cell_bus #(
   parameter int unsigned      WIDTH    = 1,
   parameter int unsigned      STAGES   = 2,
   parameter int unsigned      FILT_LEN = 0,
   parameter logic [WIDTH-1:0] RST_VAL  = {WIDTH{1'b0}}
) (
   input  logic             CP,
   input  logic             RST,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] RISE,
   output logic [WIDTH-1:0] FALL,
   output logic             CHG
);
   logic [WIDTH-1:0] sync_q [STAGES];
   logic [WIDTH-1:0] s;
   logic [WIDTH-1:0] q_prev;
   if (STAGES < 2) begin : g_bad_stages
      $error("sync_cell_bus: STAGES must be at least 2");
   end
   // Bits travel side by side through the chain; nothing mixes them before s.
   always_ff @(posedge CP or posedge RST) begin
      if (RST) begin
         for (int k = 0; k < STAGES; k++) sync_q[k] <= RST_VAL;
      end else begin
         sync_q[0] <= D;
         for (int k = 1; k < STAGES; k++) sync_q[k] <= sync_q[k-1];
      end
   end
   assign s = sync_q[STAGES-1];
   if (FILT_LEN == 0) begin : g_nofilt
      assign Q = s;
   end else begin : g_filt
      localparam int unsigned CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
      logic [CW-1:0]    cnt [WIDTH];
      logic [WIDTH-1:0] q_r;
      // Any cycle where s agrees with Q restarts the stability count.
      always_ff @(posedge CP or posedge RST) begin
         if (RST) begin
            q_r <= RST_VAL;
            for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
         end else begin
            for (int i = 0; i < WIDTH; i++) begin
               if (s[i] == q_r[i]) begin
                  cnt[i] <= '0;
               end else if (cnt[i] == CW'(FILT_LEN - 1)) begin
                  q_r[i] <= s[i];
                  cnt[i] <= '0;
               end else begin
                  cnt[i] <= cnt[i] + 1'b1;
               end
            end
         end
      end
      assign Q = q_r;
   end
   // q_prev resets with Q, so neither reset nor its release creates a pulse.
   always_ff @(posedge CP or posedge RST) begin
      if (RST) q_prev <= RST_VAL;
      else     q_prev <= Q;
   end
   assign RISE = Q & ~q_prev;
   assign FALL = ~Q & q_prev;
   assign CHG  = |(RISE | FALL);
endmodule

// File: tb/tb_sync_cell_bus.sv
// tb_sync_cell_bus: directed checks of sync_cell_bus over four parameter sets
// sharing one clock and reset.
module tb_sync_cell_bus;
   logic clk, rst;
   logic [3:0] d0, q0, r0, f0;
   logic c0;
   logic d1, q1, r1, f1, c1;
   logic d2, q2, r2, f2, c2;
   logic d3, q3, r3, f3, c3;
   int errors, checks;

   sync_cell_bus #(.WIDTH(4), .STAGES(2), .FILT_LEN(0), .RST_VAL(4'b1010)) u0 (
      .CP(clk), .RST(rst), .D(d0), .Q(q0), .RISE(r0), .FALL(f0), .CHG(c0));
   sync_cell_bus #(.WIDTH(1), .STAGES(3), .FILT_LEN(0), .RST_VAL(1'b0)) u1 (
      .CP(clk), .RST(rst), .D(d1), .Q(q1), .RISE(r1), .FALL(f1), .CHG(c1));
   sync_cell_bus #(.WIDTH(1), .STAGES(2), .FILT_LEN(4), .RST_VAL(1'b0)) u2 (
      .CP(clk), .RST(rst), .D(d2), .Q(q2), .RISE(r2), .FALL(f2), .CHG(c2));
   sync_cell_bus #(.WIDTH(1), .STAGES(2), .FILT_LEN(3), .RST_VAL(1'b0)) u3 (
      .CP(clk), .RST(rst), .D(d3), .Q(q3), .RISE(r3), .FALL(f3), .CHG(c3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] d;
      logic [3:0] q;
      logic [3:0] r;
      logic [3:0] f;
      logic       c;
   } vec_t;
   vec_t tbl [15];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string n, input logic [3:0] a, input logic [3:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %h expected %h", n, a, e);
      end
   endtask

   task automatic rst_pulse();
      rst = 1'b1;
      #2;
      chk("rst_q0", q0, 4'b1010);
      chk("rst_c0", 4'(c0), 4'd0);
      chk("rst_q2", 4'(q2), 4'd0);
      chk("rst_f2", 4'(f2), 4'd0);
      chk("rst_q3", 4'(q3), 4'd0);
      chk("rst_f3", 4'(f3), 4'd0);
      #2;
      rst = 1'b0;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      tbl[0]  = '{4'b1010, 4'b1010, 4'b0000, 4'b0000, 1'b0};
      tbl[1]  = '{4'b1010, 4'b1010, 4'b0000, 4'b0000, 1'b0};
      tbl[2]  = '{4'b0101, 4'b1010, 4'b0000, 4'b0000, 1'b0};
      tbl[3]  = '{4'b0101, 4'b0101, 4'b0101, 4'b1010, 1'b1};
      tbl[4]  = '{4'b0101, 4'b0101, 4'b0000, 4'b0000, 1'b0};
      tbl[5]  = '{4'b0111, 4'b0101, 4'b0000, 4'b0000, 1'b0};
      tbl[6]  = '{4'b0111, 4'b0111, 4'b0010, 4'b0000, 1'b1};
      tbl[7]  = '{4'b0111, 4'b0111, 4'b0000, 4'b0000, 1'b0};
      tbl[8]  = '{4'b0110, 4'b0111, 4'b0000, 4'b0000, 1'b0};
      tbl[9]  = '{4'b0110, 4'b0110, 4'b0000, 4'b0001, 1'b1};
      tbl[10] = '{4'b0110, 4'b0110, 4'b0000, 4'b0000, 1'b0};
      tbl[11] = '{4'b0111, 4'b0110, 4'b0000, 4'b0000, 1'b0};
      tbl[12] = '{4'b0110, 4'b0111, 4'b0001, 4'b0000, 1'b1};
      tbl[13] = '{4'b0110, 4'b0110, 4'b0000, 4'b0001, 1'b1};
      tbl[14] = '{4'b0110, 4'b0110, 4'b0000, 4'b0000, 1'b0};

      rst = 1'b1;
      d0 = 4'b1010;
      d1 = 1'b0;
      d2 = 1'b0;
      d3 = 1'b0;
      step();
      step();
      chk("reset_q0", q0, 4'b1010);
      chk("reset_r0", r0, 4'b0000);
      chk("reset_f0", f0, 4'b0000);
      chk("reset_c0", 4'(c0), 4'd0);
      chk("reset_q123", {1'b0, q1, q2, q3}, 4'd0);
      chk("reset_c123", {1'b0, c1, c2, c3}, 4'd0);
      rst = 1'b0;

      for (int i = 0; i < 15; i++) begin
         d0 = tbl[i].d;
         step();
         chk($sformatf("v%0d_q0", i), q0, tbl[i].q);
         chk($sformatf("v%0d_rise0", i), r0, tbl[i].r);
         chk($sformatf("v%0d_fall0", i), f0, tbl[i].f);
         chk($sformatf("v%0d_chg0", i), 4'(c0), 4'(tbl[i].c));
      end

      // three-stage chain: rise then fall, each after exactly 3 edges
      d1 = 1'b1;
      for (int e = 1; e <= 4; e++) begin
         step();
         chk($sformatf("s3_up%0d_q", e), 4'(q1), 4'(e >= 3));
         chk($sformatf("s3_up%0d_rise", e), 4'(r1), 4'(e == 3));
         chk($sformatf("s3_up%0d_chg", e), 4'(c1), 4'(e == 3));
      end
      d1 = 1'b0;
      for (int e = 1; e <= 4; e++) begin
         step();
         chk($sformatf("s3_dn%0d_q", e), 4'(q1), 4'(e < 3));
         chk($sformatf("s3_dn%0d_fall", e), 4'(f1), 4'(e == 3));
         chk($sformatf("s3_dn%0d_rise", e), 4'(r1), 4'd0);
      end

      // filter 4: a 3-cycle pulse is rejected
      d2 = 1'b1;
      for (int e = 1; e <= 10; e++) begin
         step();
         if (e == 3) d2 = 1'b0;
         chk($sformatf("f4_rej%0d_q", e), 4'(q2), 4'd0);
         chk($sformatf("f4_rej%0d_chg", e), 4'(c2), 4'd0);
      end
      // filter 4: a 4-cycle pulse passes, rising at STAGES+4 edges
      d2 = 1'b1;
      for (int e = 1; e <= 10; e++) begin
         step();
         if (e == 4) d2 = 1'b0;
         chk($sformatf("f4_acc%0d_q", e), 4'(q2), 4'(e >= 6 && e <= 9));
         chk($sformatf("f4_acc%0d_rise", e), 4'(r2), 4'(e == 6));
         chk($sformatf("f4_acc%0d_fall", e), 4'(f2), 4'(e == 10));
      end
      // filter 4: chatter high 2, low 1, then high; count restarts at the low cycle
      d2 = 1'b1;
      for (int e = 1; e <= 12; e++) begin
         step();
         if (e == 2) d2 = 1'b0;
         if (e == 3) d2 = 1'b1;
         chk($sformatf("f4_chat%0d_q", e), 4'(q2), 4'(e >= 9));
         chk($sformatf("f4_chat%0d_rise", e), 4'(r2), 4'(e == 9));
      end

      // filter 3: settle high, then reset with Q high and again mid-count
      d3 = 1'b1;
      for (int e = 1; e <= 7; e++) begin
         step();
         chk($sformatf("f3_a%0d_q", e), 4'(q3), 4'(e >= 5));
         chk($sformatf("f3_a%0d_rise", e), 4'(r3), 4'(e == 5));
      end
      rst_pulse();
      for (int e = 1; e <= 4; e++) begin
         step();
         chk($sformatf("f3_b%0d_q", e), 4'(q3), 4'd0);
      end
      rst_pulse();
      for (int e = 1; e <= 6; e++) begin
         step();
         chk($sformatf("f3_c%0d_q", e), 4'(q3), 4'(e >= 5));
         chk($sformatf("f3_c%0d_rise", e), 4'(r3), 4'(e == 5));
         chk($sformatf("f3_c%0d_fall", e), 4'(f3), 4'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
